mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the processor's single shared data/instruction memory between the control unit's fetch/load/store port and a host loader port used to program memory and inspect results. Sits between the CU/datapath and the memory array. Serialises accesses through a small FSM with programmable wait states. Stalls the requester that is not being served, and lets the host lock out the CPU while it loads a program.

## Interface
- AW, 5: memory address width (32 words).
- DW, 8: data width.
- WAIT, 1: memory access cycles per transaction; legal range 1..15.

- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; one clock, no other reset.
- cu_req  in  1  CU access request; held with its addr/we/wdata until cu_ack.
- cu_we  in  1  1 = write, 0 = read.
- cu_addr  in  AW  CU address.
- cu_wdata  in  DW  CU write data.
- cu_rdata  out  DW  registered read data; valid from the cu_ack cycle until the next CU read completes.
- cu_ack  out  1  one-cycle completion pulse.
- cu_stall  out  1  cu_req & ~cu_ack; the CU holds its state while high.
- ho_req, ho_we, ho_addr, ho_wdata, ho_rdata, ho_ack  (directions and widths as the cu_* signals): host port.
- ho_lock  in  1  while high, new CU requests are not granted.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  combinational read data from memory for mem_addr.
- owner  out  1  0 = CU, 1 = host; port currently or last granted.

## Operation
- FSM states:
  - IDLE: req sampled each edge. If a winner exists, latch owner/addr/we/wdata, load cnt=WAIT, go ACCESS.
  - ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches. cnt decrements each edge. At the edge where cnt==1: capture mem_rdata into the owner's rdata register (reads only), go DONE.
  - DONE: owner's ack=1 for exactly this cycle, mem_en=0. Next state is always IDLE.
- Arbitration (IDLE only):
  - Eligible CU = cu_req & ~ho_lock. Eligible host = ho_req.
  - One eligible: that port wins.
  - Both eligible: the port not served last wins (round-robin, 1-bit pointer updated on each grant).
- Writes: mem_we held high for all WAIT ACCESS cycles with constant addr/data. The memory may commit on any of those cycles; repeated commits are harmless.
- Port inputs are only sampled at the IDLE grant edge. Changes afterwards do not affect the in-flight access.
- A req still high in the IDLE cycle after DONE is treated as a new request.
- A req dropped before its ack: the access still completes and ack still pulses.
- ho_lock rising during a CU access does not abort it. The lock only blocks new CU grants.
- Unselected port's rdata registers hold their value.

## Timing
- Reset values, asynchronous assertion:
  - State IDLE, cnt=0.
  - cu_ack=ho_ack=0, cu_rdata=ho_rdata=0.
  - mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
  - owner=0, pointer favours CU.
- Reset mid-ACCESS: mem_we drops immediately. The write may or may not have committed. No ack is issued.
- Latency: req high at IDLE edge E → ACCESS cycles E+1..E+WAIT → ack high during cycle E+WAIT+1.
- Back-to-back throughput per port: WAIT+2 cycles.
- Worst-case wait for an eligible requester: one full foreign transaction plus its own (2·(WAIT+2) cycles). ho_lock can starve the CU indefinitely, by design.
- Outputs are registered or decoded from state only; no combinational path from req to mem_*. cu_stall is the only combinational output.

## Structure
- Shared package cpu_pkg: arb_state_t enum {IDLE, ACCESS, DONE}; OWNER_CU=0, OWNER_HOST=1; default AW/DW constants shared with the CU and memory.
- One sub-module: rr_arb2. It is the 2-requester round-robin picker holding the last-grant pointer, with inputs req[1:0] and a grant-enable strobe, and output one-hot grant.
- The FSM, latches, wait counter and rdata registers live in mem_arbiter.

## Test plan
- Reset then CU read, WAIT=1, mem[3]=8'hA5: cu_req, addr=3 at edge 0 → mem_en in cycle 1, cu_ack in cycle 2, cu_rdata=8'hA5, cu_stall high in cycles 0–1.
- Simultaneous CU read and host write to addr 7 (8'h3C) from reset: CU served first (ack cycle 2); host granted in the next IDLE, ho_ack 4 cycles later; a following CU read of 7 returns 8'h3C.
- ho_lock=1 with cu_req held for 20 cycles: no cu_ack. Three host writes complete. Dropping ho_lock → CU granted at the next IDLE edge.
- WAIT=3 host write: mem_we high exactly 3 consecutive cycles with constant addr/data; ho_ack in cycle 4 after grant; no mem_en in the DONE cycle.
- Reset asserted in the second ACCESS cycle of a CU write: mem_en/mem_we/cu_ack go 0 without a clock edge. After release the state is IDLE, and a held cu_req is re-granted.
- Continuous requests on both ports for 40 cycles: grants strictly alternate, and each port's acks are exactly 2·(WAIT+2) cycles apart.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor definitions: arbiter state encoding, port ownership codes
// and the default bus widths used by the CU, the memory and the arbiter.
package cpu_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;
    localparam int CNT_W  = 4;

    localparam logic OWNER_CU   = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: req[0] is the CU, req[1] the host.
// The pointer remembers who was granted last and only moves on a real grant.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last_host;

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last_host ? 2'b01 : 2'b10;
    end

    // Reset as if the host went last so the CU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_host <= 1'b1;
        else if (en && (gnt != 2'b00))
            last_host <= gnt[OWNER_HOST];
    end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises CU and host accesses onto the single memory port with WAIT
// access cycles per transaction; the host can lock the CU out while loading.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cu_req,
    input  logic          cu_we,
    input  logic [AW-1:0] cu_addr,
    input  logic [DW-1:0] cu_wdata,
    output logic [DW-1:0] cu_rdata,
    output logic          cu_ack,
    output logic          cu_stall,
    input  logic          ho_req,
    input  logic          ho_we,
    input  logic [AW-1:0] ho_addr,
    input  logic [DW-1:0] ho_wdata,
    output logic [DW-1:0] ho_rdata,
    output logic          ho_ack,
    input  logic          ho_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);
    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             pick_host;

    assign req       = {ho_req, cu_req & ~ho_lock};
    assign pick_host = gnt[OWNER_HOST];
    assign cu_stall  = cu_req & ~cu_ack;

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (state == IDLE),
        .gnt   (gnt)
    );

    // mem_addr/mem_wdata double as the transaction latches; mem_en/mem_we
    // are only ever high in ACCESS, so no request path reaches the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cu_ack    <= 1'b0;
            ho_ack    <= 1'b0;
            cu_rdata  <= '0;
            ho_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= OWNER_CU;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        owner     <= pick_host;
                        mem_addr  <= pick_host ? ho_addr  : cu_addr;
                        mem_wdata <= pick_host ? ho_wdata : cu_wdata;
                        mem_we    <= pick_host ? ho_we    : cu_we;
                        mem_en    <= 1'b1;
                        cnt       <= CNT_W'(WAIT);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner == OWNER_HOST) begin
                            ho_ack <= 1'b1;
                            if (!mem_we) ho_rdata <= mem_rdata;
                        end else begin
                            cu_ack <= 1'b1;
                            if (!mem_we) cu_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    cu_ack <= 1'b0;
                    ho_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference (grant edge + fixed
// offsets, round-robin by "last served") checked every cycle, plus directed scenarios.
module tb_mem_arbiter;
    localparam int W  = 3;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk, rst_n;
    logic          cu_req, cu_we, ho_req, ho_we, ho_lock;
    logic [AW-1:0] cu_addr, ho_addr, mem_addr;
    logic [DW-1:0] cu_wdata, ho_wdata, cu_rdata, ho_rdata, mem_wdata, mem_rdata;
    logic          cu_ack, ho_ack, cu_stall, mem_en, mem_we, owner;

    int nvec, nmis;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cu_req(cu_req), .cu_we(cu_we), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
        .cu_rdata(cu_rdata), .cu_ack(cu_ack), .cu_stall(cu_stall),
        .ho_req(ho_req), .ho_we(ho_we), .ho_addr(ho_addr), .ho_wdata(ho_wdata),
        .ho_rdata(ho_rdata), .ho_ack(ho_ack), .ho_lock(ho_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array seen by the DUT
    logic [DW-1:0] mem [32];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

    // Reference model: a transaction granted at edge g is on the bus for the
    // cycles after edges g..g+W-1, acks after edge g+W, next decision at g+W+2.
    int            cyc, m_next, m_g, n_g;
    logic          m_host, m_last_host, m_we, n_h, n_w, ec, win, win_host;
    logic [AW-1:0] m_addr, n_a;
    logic [DW-1:0] m_wdata, n_d;
    logic [DW-1:0] ref_mem [32];
    logic          e_en, e_we, e_cu_ack, e_ho_ack, e_owner;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_cu_rd, e_ho_rd;

    always_comb begin
        ec       = cu_req && !ho_lock;
        win      = (cyc == m_next) && (ec || ho_req);
        win_host = ho_req && (!ec || !m_last_host);
        n_g      = win ? cyc : m_g;
        n_h      = win ? win_host : m_host;
        n_w      = win ? (win_host ? ho_we : cu_we) : m_we;
        n_a      = win ? (win_host ? ho_addr : cu_addr) : m_addr;
        n_d      = win ? (win_host ? ho_wdata : cu_wdata) : m_wdata;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_next <= 0; m_g <= -100; m_host <= 1'b0; m_last_host <= 1'b1;
            m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
            e_en <= 1'b0; e_we <= 1'b0; e_cu_ack <= 1'b0; e_ho_ack <= 1'b0; e_owner <= 1'b0;
            e_addr <= '0; e_wdata <= '0; e_cu_rd <= '0; e_ho_rd <= '0;
        end else begin
            cyc <= cyc + 1;
            if (cyc == m_next) m_next <= win ? cyc + W + 2 : cyc + 1;
            if (win) m_last_host <= win_host;
            m_g <= n_g; m_host <= n_h; m_we <= n_w; m_addr <= n_a; m_wdata <= n_d;
            e_en     <= (cyc >= n_g) && (cyc < n_g + W);
            e_we     <= (cyc >= n_g) && (cyc < n_g + W) && n_w;
            e_cu_ack <= (cyc == n_g + W) && !n_h;
            e_ho_ack <= (cyc == n_g + W) && n_h;
            e_owner  <= n_h; e_addr <= n_a; e_wdata <= n_d;
            if (cyc == n_g + W) begin
                if (n_w)       ref_mem[n_a] <= n_d;
                else if (n_h)  e_ho_rd <= ref_mem[n_a];
                else           e_cu_rd <= ref_mem[n_a];
            end
        end
    end

    logic [34:0] obs, expv;
    assign obs  = {mem_en, mem_we, mem_addr, mem_wdata, cu_ack, ho_ack, cu_rdata, ho_rdata, owner, cu_stall};
    assign expv = {e_en, e_we, e_addr, e_wdata, e_cu_ack, e_ho_ack, e_cu_rd, e_ho_rd, e_owner, cu_req & ~e_cu_ack};

    task automatic clear_inputs();
        cu_req = 0; cu_we = 0; cu_addr = '0; cu_wdata = '0;
        ho_req = 0; ho_we = 0; ho_addr = '0; ho_wdata = '0; ho_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 0;
        @(negedge clk);
        ho_req = 1; ho_we = 1; ho_addr = a; ho_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ho_ack) got = 1;
        end
        ho_req = 0; ho_we = 0;
        nvec++;
        if (!got) begin nmis++; $display("FAIL host_write timeout: ho_ack=0 want 1 addr=%0d", a); end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        nvec++;
        if (obs !== 35'd0) begin nmis++; $display("FAIL reset_vals: got %h want 0", obs); end
        @(negedge clk); rst_n = 1'b1;
        nvec++;
        if (obs !== expv) begin nmis++; $display("FAIL reset_model: got %h want %h", obs, expv); end
    endtask

    task automatic test_cu_read();
        int ack_at;
        ack_at = 0;
        host_write(5'd3, 8'hA5);
        @(negedge clk);
        cu_req = 1; cu_we = 0; cu_addr = 5'd3;
        for (int i = 1; i <= 10 && ack_at == 0; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL cu_read cyc%0d: got %h want %h", i, obs, expv); end
            if (cu_ack) begin
                ack_at = i; cu_req = 0;
            end else begin
                nvec++;
                if (cu_stall !== 1'b1 || mem_en !== (i <= W)) begin
                    nmis++; $display("FAIL cu_read_stall cyc%0d: stall=%b en=%b want stall=1 en=%b", i, cu_stall, mem_en, i <= W);
                end
            end
        end
        nvec++;
        if (ack_at != W + 1 || cu_rdata !== 8'hA5) begin
            nmis++; $display("FAIL cu_read_lat: ack_at=%0d rdata=%h want %0d a5", ack_at, cu_rdata, W + 1);
        end
    endtask

    task automatic test_simultaneous();
        int cu_at, ho_at, rd_at;
        cu_at = 0; ho_at = 0; rd_at = 0;
        clear_inputs();
        do_reset();
        cu_req = 1; cu_we = 0; cu_addr = 5'd7;
        ho_req = 1; ho_we = 1; ho_addr = 5'd7; ho_wdata = 8'h3C;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL simul cyc%0d: got %h want %h", i, obs, expv); end
            if (cu_ack && cu_at == 0) begin cu_at = i; cu_req = 0; end
            if (ho_ack && ho_at == 0) begin ho_at = i; ho_req = 0; ho_we = 0; end
        end
        nvec++;
        if (cu_at != W + 1 || ho_at != 2 * W + 3) begin
            nmis++; $display("FAIL simul_order: cu_at=%0d ho_at=%0d want %0d %0d", cu_at, ho_at, W + 1, 2 * W + 3);
        end
        cu_req = 1; cu_addr = 5'd7;
        for (int i = 1; i <= 10 && rd_at == 0; i++) begin
            @(negedge clk);
            if (cu_ack) begin rd_at = i; cu_req = 0; end
        end
        nvec++;
        if (rd_at == 0 || cu_rdata !== 8'h3C) begin
            nmis++; $display("FAIL simul_readback: rdata=%h ack_at=%0d want 3c", cu_rdata, rd_at);
        end
    endtask

    task automatic test_lock();
        int nw, ncu, at;
        nw = 0; ncu = 0; at = 0;
        @(negedge clk);
        ho_lock = 1; cu_req = 1; cu_we = 0; cu_addr = 5'd9;
        ho_req = 1; ho_we = 1; ho_addr = 5'd10; ho_wdata = 8'h11;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL lock cyc%0d: got %h want %h", i, obs, expv); end
            if (cu_ack) ncu++;
            if (ho_ack) begin
                nw++;
                ho_addr = ho_addr + 1'b1; ho_wdata = ho_wdata + 8'h11;
                if (nw == 3) begin ho_req = 0; ho_we = 0; end
            end
        end
        nvec++;
        if (ncu != 0 || nw != 3) begin nmis++; $display("FAIL lock_block: cu_acks=%0d ho_acks=%0d want 0 3", ncu, nw); end
        ho_lock = 0;
        for (int i = 1; i <= 10 && at == 0; i++) begin
            @(negedge clk);
            if (cu_ack) begin at = i; cu_req = 0; end
        end
        nvec++;
        if (at != W + 1) begin nmis++; $display("FAIL lock_release: ack_at=%0d want %0d", at, W + 1); end
    endtask

    task automatic test_wait_write();
        int nwe, first, last, at;
        bit bad;
        nwe = 0; first = 0; last = 0; at = 0; bad = 0;
        @(negedge clk);
        ho_req = 1; ho_we = 1; ho_addr = 5'd20; ho_wdata = 8'h5A;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL wait_write cyc%0d: got %h want %h", i, obs, expv); end
            if (mem_we) begin
                nwe++; last = i;
                if (first == 0) first = i;
                if (mem_addr !== 5'd20 || mem_wdata !== 8'h5A) bad = 1;
            end
            if (ho_ack && at == 0) begin
                at = i; ho_req = 0; ho_we = 0;
                if (mem_en !== 1'b0) bad = 1;
            end
        end
        nvec++;
        if (nwe != W || last - first != W - 1 || at != W + 1 || bad) begin
            nmis++; $display("FAIL wait_write_shape: we_cycles=%0d span=%0d ack_at=%0d bad=%0d want %0d %0d %0d 0",
                             nwe, last - first + 1, at, bad, W, W, W + 1);
        end
    endtask

    task automatic test_reset_mid();
        int at;
        at = 0;
        @(negedge clk);
        cu_req = 1; cu_we = 1; cu_addr = 5'd12; cu_wdata = ref_mem[12];
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if (mem_we !== 1'b1) begin nmis++; $display("FAIL rst_mid_pre: mem_we=%b want 1", mem_we); end
        rst_n = 1'b0;
        #1;
        nvec++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || cu_ack !== 1'b0) begin
            nmis++; $display("FAIL rst_mid_async: en=%b we=%b ack=%b want 0 0 0", mem_en, mem_we, cu_ack);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 10 && at == 0; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL rst_mid cyc%0d: got %h want %h", i, obs, expv); end
            if (cu_ack) begin at = i; cu_req = 0; cu_we = 0; end
        end
        nvec++;
        if (at != W + 1) begin nmis++; $display("FAIL rst_mid_regrant: ack_at=%0d want %0d", at, W + 1); end
    endtask

    task automatic test_back_to_back();
        int last_cu, last_ho, last_port, nacks;
        last_cu = 0; last_ho = 0; last_port = -1; nacks = 0;
        @(negedge clk);
        cu_req = 1; cu_we = 0; cu_addr = 5'd1;
        ho_req = 1; ho_we = 0; ho_addr = 5'd2;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL b2b cyc%0d: got %h want %h", i, obs, expv); end
            if (cu_ack || ho_ack) begin
                nacks++;
                nvec++;
                if ((cu_ack && ho_ack) || (last_port == 0 && cu_ack) || (last_port == 1 && ho_ack) ||
                    (cu_ack && last_cu != 0 && i - last_cu != 2 * (W + 2)) ||
                    (ho_ack && last_ho != 0 && i - last_ho != 2 * (W + 2))) begin
                    nmis++; $display("FAIL b2b_alt cyc%0d: cu_ack=%b ho_ack=%b last_port=%0d gap_cu=%0d gap_ho=%0d want gap %0d",
                                     i, cu_ack, ho_ack, last_port, i - last_cu, i - last_ho, 2 * (W + 2));
                end
                if (cu_ack) begin last_cu = i; last_port = 0; end
                if (ho_ack) begin last_ho = i; last_port = 1; end
            end
        end
        nvec++;
        if (nacks < 40 / (W + 2) - 1) begin nmis++; $display("FAIL b2b_count: acks=%0d want >=%0d", nacks, 40 / (W + 2) - 1); end
        clear_inputs();
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL random cyc%0d: got %h want %h", i, obs, expv); end
            cu_req   = ($urandom_range(3) != 0);
            cu_we    = $urandom_range(1);
            cu_addr  = AW'($urandom);
            cu_wdata = DW'($urandom);
            ho_req   = ($urandom_range(2) == 0);
            ho_we    = $urandom_range(1);
            ho_addr  = AW'($urandom);
            ho_wdata = DW'($urandom);
            ho_lock  = ($urandom_range(7) == 0);
        end
        clear_inputs();
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== expv) begin nmis++; $display("FAIL random_drain cyc%0d: got %h want %h", i, obs, expv); end
        end
    endtask

    initial begin
        nvec = 0; nmis = 0;
        test_reset();
        for (int a = 0; a < 32; a++) host_write(AW'(a), DW'($urandom));
        test_cu_read();
        test_simultaneous();
        test_lock();
        test_wait_write();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
